// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath blocks (streamer, FIR core, writeback).
package fir_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } stream_state_t;

endpackage

// File: rtl/fir_skid_fifo.sv
// Two-entry register FIFO carrying a sample plus its end-of-block tag.
// The head entry drives the downstream interface directly from flops.
module fir_skid_fifo #(
  parameter int unsigned DATA_W = fir_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last
);

  logic [DATA_W-1:0] d0, d1;
  logic              l0, l1;
  logic [1:0]        cnt;

  // Entry 0 is always the head; entry 1 only holds data when two are buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= push_data;
            l0 <= push_last;
          end else begin
            d1 <= push_data;
            l1 <= push_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= push_data;
            l0 <= push_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= push_data;
            l1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != 2'd0);
  assign head_data  = d0;
  // Stale tag left behind by the final pop must not be visible.
  assign head_last  = l0 & head_valid;

endmodule

// File: rtl/fir_sample_streamer.sv
// Reads a block of samples from the sample BRAM and streams them to the FIR
// input over valid/ready, hiding the 1-cycle BRAM latency and absorbing
// back-pressure with a 2-entry output buffer.
module fir_sample_streamer #(
  parameter int unsigned DATA_W     = fir_pkg::DATA_W,
  parameter int unsigned ADDR_W     = fir_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  import fir_pkg::*;

  stream_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued;
  logic              inflight;
  logic              inflight_last;

  logic              pop;
  logic              issue;
  logic              issue_last;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic [2:0]        limit;

  assign pop = m_valid & m_ready;

  // A slot freed by this cycle's pop can be refilled by a read issued now,
  // which keeps one transfer per clock without ever overfilling the buffer.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
  assign limit      = 3'(FIFO_DEPTH) + {2'b00, pop};
  assign issue      = (state == RUN) && (issued != len_q) && (occupancy < limit);
  assign issue_last = ((issued + (ADDR_W+1)'(1)) == len_q);

  assign bram_en   = issue;
  assign bram_addr = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Block sequencing, address/issue counting and read-latency tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      len_q         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue & issue_last;
      case (state)
        IDLE: begin
          if (start) begin
            addr   <= base_addr;
            len_q  <= len;
            issued <= '0;
            state  <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr   <= addr + ADDR_W'(1);
            issued <= issued + (ADDR_W+1)'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fir_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (bram_dout),
    .push_last (inflight_last),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(m_valid),
    .head_data (m_data),
    .head_last (m_last)
  );

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Directed bench for fir_sample_streamer with a behavioural sample BRAM.
module tb_fir_sample_streamer;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;

  fir_sample_streamer #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .bram_en  (bram_en),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Transfer/read monitor state
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  int            addr_q[$];
  int            en_total, xfer_total, first_cyc, last_cyc, valid_cycles;
  bit            prev_stall;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    addr_q.delete();
    en_total = 0;
    xfer_total = 0;
    first_cyc = -1;
    last_cyc = -1;
    valid_cycles = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", 32'(m_data), 32'(prev_d));
        chk("hold_last", 32'(m_last), 32'(prev_l));
      end
      if (m_valid) valid_cycles++;
      if (bram_en) begin
        int outst;
        outst = en_total + 1 - xfer_total - ((m_valid && m_ready) ? 1 : 0);
        chk("outstanding_le2", 32'(outst <= 2), 32'd1);
        addr_q.push_back(int'(bram_addr));
        en_total++;
      end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        if (xfer_total == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_total++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: m_ready held high; mode 1: m_ready cycles 1,0,0,1.
  // poke: re-assert start with a different block while the first one runs.
  task automatic run_block(input int base, input int n, input int mode, input bit poke);
    int  done_cyc;
    int  e0c;
    int  rp;
    int  ea;
    bit  pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rp = 0;
    done_cyc = -1;
    clear_mon();
    base_addr = AW'(base);
    len = (AW+1)'(n);
    start = 1'b1;
    m_ready = (mode == 0);
    tick();
    e0c = cyc;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (n > 0) begin
      chk("en_at_e0", 32'(bram_en), 32'd1);
      chk("addr_at_e0", 32'(bram_addr), 32'(base));
      chk("valid_at_e0", 32'(m_valid), 32'd0);
    end
    for (int k = 0; k < n + 100; k++) begin
      if (n > 0 && k == 1) chk("valid_at_e1", 32'(m_valid), 32'd0);
      if (n > 0 && k == 2) chk("valid_at_e2", 32'(m_valid), 32'd1);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 1) begin
        m_ready = pat[rp % 4];
        rp++;
      end
      if (poke && k == 1) begin
        start = 1'b1;
        base_addr = AW'(500);
        len = (AW+1)'(3);
      end else if (poke && k == 2) begin
        start = 1'b0;
      end
      tick();
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    if (done_cyc >= 0) begin
      chk("busy_with_done", 32'(busy), 32'd1);
      if (n > 0) chk("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
      else       chk("done_len0_cycle", 32'(done_cyc), 32'(e0c));
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
    end
    chk("xfer_count", 32'(xfer_total), 32'(n));
    chk("read_count", 32'(en_total), 32'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      ea = (base + i) % 1024;
      chk("data", 32'(got_d[i]), 32'(ea + 100));
      chk("last", 32'(got_l[i]), 32'(i == n - 1));
    end
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      chk("bram_addr", 32'(addr_q[i]), 32'((base + i) % 1024));
    end
    if (mode == 0 && n > 0) begin
      chk("first_latency", 32'(first_cyc), 32'(e0c + 2));
      chk("no_bubbles", 32'(last_cyc - first_cyc), 32'(n - 1));
    end
    if (n == 0) chk("no_valid_len0", 32'(valid_cycles), 32'd0);
    m_ready = 1'b0;
    tick();
  endtask

  task automatic reset_abort();
    bit done_any;
    done_any = 1'b0;
    clear_mon();
    base_addr = AW'(10);
    len = (AW+1)'(8);
    start = 1'b1;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (xfer_total >= 2) break;
      tick();
    end
    chk("abort_reached_2", 32'(xfer_total >= 2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bram_en", 32'(bram_en), 32'd0);
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_m_last", 32'(m_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr", 32'(bram_addr), 32'd0);
    chk("abort_data", 32'(m_data), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      if (done || busy) done_any = 1'b1;
    end
    chk("abort_no_done", 32'(done_any), 32'd0);
    chk("abort_xfers", 32'(xfer_total), 32'd2);
    m_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 100);
    clear_mon();
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    run_block(0, 5, 0, 1'b0);
    run_block(0, 5, 1, 1'b0);
    run_block(1022, 4, 0, 1'b0);
    run_block(0, 0, 0, 1'b0);
    run_block(300, 6, 0, 1'b1);
    run_block(7, 7, 1, 1'b1);
    reset_abort();
    run_block(200, 3, 0, 1'b0);
    run_block(5, 1024, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_sample_streamer.md
Name: fir_sample_streamer

Overview:
- Upstream feeder for the pipelined FIR: on a start strobe, reads a block of input samples from the sample BRAM and streams them into the FIR's stage-1 input over a valid/ready handshake.
- Hides the 1-cycle synchronous BRAM read latency and absorbs FIR back-pressure without dropping or duplicating samples.
- Sustains one sample per clock while the FIR accepts.

Parameters:
- DATA_W, 16, sample width (signed, passed through unmodified).
- ADDR_W, 10, BRAM address width; addresses wrap modulo 2^ADDR_W.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2 (credit logic sized for it).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first BRAM address; latched on accepted start.
- len  in  ADDR_W+1  sample count, 0..2^ADDR_W; latched on accepted start.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  DATA_W  BRAM read data, valid 1 cycle after bram_en.
- m_valid  out  1  sample available to the FIR.
- m_data  out  DATA_W  sample.
- m_last  out  1  high with the final sample of the block.
- m_ready  in  1  FIR accepts; transfer when m_valid && m_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  1-cycle pulse at block end.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; bram_en, m_valid, m_last, busy, done=0; bram_addr, m_data=0; FIFO empty; in-flight flag=0.
- FSM: IDLE -> RUN on start (len>0); IDLE -> DONE on start with len=0; RUN -> DRAIN after the len-th read is issued; DRAIN -> DONE on the handshake of the m_last sample; DONE -> IDLE unconditionally (done=1 in DONE only).
- busy=1 in RUN, DRAIN, and DONE.
- Read issue (RUN only): bram_en=1 when fifo_count + inflight - pop < 2, where pop = m_valid && m_ready this cycle. Each issue increments bram_addr (wrapping) and the issued count.
- Capture: the cycle after bram_en, bram_dout is pushed into the FIFO, tagged last when it is the len-th read.
- Latency: start high at edge E0 -> bram_en=1, bram_addr=base during cycle E0..E1 -> m_valid=1 after E2. First sample appears 2 cycles after start.
- Throughput: with m_ready held high, one transfer per cycle, with no bubbles after the first.
- Back-pressure: while m_valid && !m_ready, m_data and m_last hold stable. Reads stall once 2 samples are buffered or in flight, so the FIFO never overflows.
- m_valid, m_data, and m_last come directly from the FIFO head register (no combinational path from m_ready to m_valid).
- start outside IDLE is ignored; base_addr and len are not re-sampled.
- Address wrap: base_addr + i is taken mod 2^ADDR_W. Example: base=1022, len=4 reads 1022, 1023, 0, 1.
- len=2^ADDR_W streams the whole BRAM once. The counter is ADDR_W+1 bits wide, so there is no overflow.
- m_ready may be asserted while m_valid=0; this has no effect.
- Reset mid-block aborts immediately. No done pulse; outstanding BRAM data is discarded.

Decomposition:
- Shared package fir_pkg: DATA_W, ADDR_W, and the streamer state enum (IDLE, RUN, DRAIN, DONE), reused by the FIR and writeback blocks.
- One sub-module, fir_skid_fifo: 2-entry register FIFO with push/pop, count, and a data+last payload.
- FSM, address counter, and credit logic stay in fir_sample_streamer.

Test Plan:
- BRAM[i]=i+100, base=0, len=5, m_ready=1 -> m_data 100..104 on 5 consecutive cycles starting 2 cycles after start; m_last only on 104; done pulses the cycle after the 104 handshake; busy falls with done.
- Same setup with m_ready toggling 1,0,0,1,… -> identical sequence 100..104 with no loss or duplication; m_data stable while stalled; bram_en never issues a third outstanding read.
- base=1022, len=4 -> bram_addr sequence 1022, 1023, 0, 1; data order matches.
- len=0 -> no bram_en and no m_valid; done pulses the cycle after the DONE entry (1 cycle after start).
- start re-asserted during RUN with different base/len -> ignored; the original block completes unchanged.
- rst_n pulsed low after the 2nd transfer of len=8 -> all outputs 0 immediately; no done; a new start afterward streams the new block correctly from its base.
